star_locator: RTL

- Raster-scans the frame buffer for bright pixels, one pixel at a time, and produces a clamped bounding box around each star it finds.
- For each star it hands the box to the downstream star-cleaning stage with a one-cycle goClean pulse, then waits for that stage's doneClean pulse.
- Once the box is cleaned it resumes the scan at the next pixel. Cleaned pixels read back black, so the same star is never re-detected.
- Sits directly upstream of the cleaner; the frame-buffer read port and the found-star stream are shared with the top level.

---
 rtl/star_pkg.sv | 32 +++
 rtl/star_box_clamp.sv | 30 +++
 rtl/star_locator.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/star_pkg.sv
// Shared types and frame geometry for the star locator and its neighbouring stages.
`default_nettype none

package star_pkg;

  localparam int xSz   = 3;
  localparam int ySz   = 3;
  localparam int colSz = 3;
  localparam int X_MAX = 7;
  localparam int Y_MAX = 7;
  localparam int BOX_R = 1;

  localparam logic [colSz-1:0] THRESH = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ       = 3'd1,
    ST_CHECK      = 3'd2,
    ST_BOX        = 3'd3,
    ST_CLEAN      = 3'd4,
    ST_WAIT_CLEAN = 3'd5,
    ST_NEXT       = 3'd6,
    ST_DONE       = 3'd7
  } state_t;

  function automatic logic is_bright(input logic [colSz-1:0] col);
    return col >= THRESH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/star_box_clamp.sv
// Clamps a +/-R window around one coordinate to the range 0..MAX without wrapping.
`default_nettype none

module star_box_clamp #(
  parameter int W   = 3,
  parameter int R   = 1,
  parameter int MAX = 7
) (
  input  logic [W-1:0] i_coord,
  output logic [W-1:0] o_lo,
  output logic [W-1:0] o_hi
);

  localparam int WE = W + 1;

  localparam logic [W:0]   C_R_EXT  = WE'(R);
  localparam logic [W:0]   C_HI_LIM = WE'(MAX - R);
  localparam logic [W-1:0] C_R      = W'(R);
  localparam logic [W-1:0] C_MAX    = W'(MAX);

  logic [W:0] w_coord_ext;

  // Decisions are made one bit wider; the narrow add/sub only runs where it cannot wrap.
  assign w_coord_ext = {1'b0, i_coord};
  assign o_lo = (w_coord_ext < C_R_EXT)  ? '0    : i_coord - C_R;
  assign o_hi = (w_coord_ext > C_HI_LIM) ? C_MAX : i_coord + C_R;

endmodule

`default_nettype wire

// File: rtl/star_locator.sv
// ============================================================================
// Module      : star_locator
// Description : Raster-scans the frame buffer, boxes each bright pixel and
//               hands it to the cleaner. Optional watchdog on the cleaner
//               handshake: define STAR_LOCATOR_TIMEOUT_EN.
// Revision    : 1.1
// ============================================================================
`default_nettype none

module star_locator
    import star_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             goFind,
    output logic [xSz-1:0]   rdX,
    output logic [ySz-1:0]   rdY,
    input  logic [colSz-1:0] pixCol,
    output logic [xSz-1:0]   xLeft,
    output logic [xSz-1:0]   xRight,
    output logic [ySz-1:0]   yTop,
    output logic [ySz-1:0]   yBottom,
    output logic             goClean,
    input  logic             doneClean,
    output logic [xSz-1:0]   starX,
    output logic [ySz-1:0]   starY,
    output logic             starValid,
    output logic [7:0]       starCount,
    output logic             doneFind,
    output logic             timeoutErr
);

    localparam logic [xSz-1:0] C_X_LAST = xSz'(X_MAX);
    localparam logic [ySz-1:0] C_Y_LAST = ySz'(Y_MAX);

    state_t           r_state;
    logic [xSz-1:0]   r_rd_x;
    logic [ySz-1:0]   r_rd_y;
    logic [xSz-1:0]   r_star_x;
    logic [ySz-1:0]   r_star_y;
    logic [xSz-1:0]   r_x_left;
    logic [xSz-1:0]   r_x_right;
    logic [ySz-1:0]   r_y_top;
    logic [ySz-1:0]   r_y_bottom;
    logic [7:0]       r_star_count;
    logic             r_go_clean;
    logic             r_star_valid;
    logic             r_done_find;

    logic [xSz-1:0]   w_x_lo;
    logic [xSz-1:0]   w_x_hi;
    logic [ySz-1:0]   w_y_lo;
    logic [ySz-1:0]   w_y_hi;
    logic             w_last;
    logic [xSz-1:0]   w_next_x;
    logic [ySz-1:0]   w_next_y;

    star_box_clamp #(.W(xSz), .R(BOX_R), .MAX(X_MAX)) u_clamp_x (
        .i_coord (r_star_x),
        .o_lo    (w_x_lo),
        .o_hi    (w_x_hi)
    );

    star_box_clamp #(.W(ySz), .R(BOX_R), .MAX(Y_MAX)) u_clamp_y (
        .i_coord (r_star_y),
        .o_lo    (w_y_lo),
        .o_hi    (w_y_hi)
    );

    assign w_last   = (r_rd_x == C_X_LAST) && (r_rd_y == C_Y_LAST);
    assign w_next_x = (r_rd_x == C_X_LAST) ? '0 : r_rd_x + 1'b1;
    assign w_next_y = (r_rd_x == C_X_LAST) ? r_rd_y + 1'b1 : r_rd_y;

`ifdef STAR_LOCATOR_TIMEOUT_EN
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);
    logic [7:0] r_tmo_cnt;
    logic       r_timeout_err;
    assign timeoutErr = r_timeout_err;
`else
    assign timeoutErr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rd_x       <= '0;
            r_rd_y       <= '0;
            r_star_x     <= '0;
            r_star_y     <= '0;
            r_x_left     <= '0;
            r_x_right    <= '0;
            r_y_top      <= '0;
            r_y_bottom   <= '0;
            r_star_count <= '0;
            r_go_clean   <= 1'b0;
            r_star_valid <= 1'b0;
            r_done_find  <= 1'b0;
`ifdef STAR_LOCATOR_TIMEOUT_EN
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_go_clean   <= 1'b0;
            r_star_valid <= 1'b0;
            r_done_find  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (goFind) begin
                        r_rd_x       <= '0;
                        r_rd_y       <= '0;
                        r_star_count <= '0;
`ifdef STAR_LOCATOR_TIMEOUT_EN
                        r_timeout_err <= 1'b0;
`endif
                        r_state      <= ST_READ;
                    end
                end
                ST_READ: r_state <= ST_CHECK;
                ST_CHECK: begin
                    if (is_bright(pixCol)) begin
                        r_star_x <= r_rd_x;
                        r_star_y <= r_rd_y;
                        r_state  <= ST_BOX;
                    end else if (w_last) begin
                        r_done_find <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_rd_x  <= w_next_x;
                        r_rd_y  <= w_next_y;
                        r_state <= ST_READ;
                    end
                end
                ST_BOX: begin
                    r_x_left     <= w_x_lo;
                    r_x_right    <= w_x_hi;
                    r_y_top      <= w_y_lo;
                    r_y_bottom   <= w_y_hi;
                    if (r_star_count != 8'hFF) r_star_count <= r_star_count + 8'd1;
                    r_go_clean   <= 1'b1;
                    r_star_valid <= 1'b1;
                    r_state      <= ST_CLEAN;
                end
                ST_CLEAN: begin
`ifdef STAR_LOCATOR_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                    r_state <= ST_WAIT_CLEAN;
                end
                ST_WAIT_CLEAN: begin
                    if (doneClean) begin
                        r_state <= ST_NEXT;
                    end
`ifdef STAR_LOCATOR_TIMEOUT_EN
                    else if (r_tmo_cnt == c_tmo_last) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_NEXT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
`endif
                end
                ST_NEXT: begin
                    // The resumed read follows cleaning, so the current star reads back black.
                    if (w_last) begin
                        r_done_find <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_rd_x  <= w_next_x;
                        r_rd_y  <= w_next_y;
                        r_state <= ST_READ;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rdX       = r_rd_x;
    assign rdY       = r_rd_y;
    assign starX     = r_star_x;
    assign starY     = r_star_y;
    assign xLeft     = r_x_left;
    assign xRight    = r_x_right;
    assign yTop      = r_y_top;
    assign yBottom   = r_y_bottom;
    assign starCount = r_star_count;
    assign goClean   = r_go_clean;
    assign starValid = r_star_valid;
    assign doneFind  = r_done_find;

endmodule

`default_nettype wire
